arbitro_rr_salida: RTL and testbench
====================================

Name: arbitro_rr_salida

Overview:
- Egress side of the PCIE FIFO datapath: the counterpart of the class demux that splits the 12-bit ingress stream into four output FIFOs.
- Drains the four per-class FIFOs (VC0..VC3) with round-robin arbitration and merges them into one 12-bit stream for the downstream egress FIFO.
- Honours downstream back-pressure.
- Keeps per-class and total word counters, readable through the same req/idx counter interface as the ingress side.

Parameters:
- TAMANO_DATOS, 12, data word width.
- ANCHO_CONTADOR, 5, width of each word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- empty_in  input  4  empty flags of FIFOs VC3..VC0 (bit i = VCi).
- data_in0  input  TAMANO_DATOS  registered read data of VC0 FIFO.
- data_in1  input  TAMANO_DATOS  registered read data of VC1 FIFO.
- data_in2  input  TAMANO_DATOS  registered read data of VC2 FIFO.
- data_in3  input  TAMANO_DATOS  registered read data of VC3 FIFO.
- almost_full_in  input  1  downstream egress FIFO almost-full flag (pause request).
- pop_out  output  4  one-hot pop to VC FIFOs.
- data_out  output  TAMANO_DATOS  merged data word to the downstream FIFO.
- push_out  output  1  write strobe for data_out.
- req  input  1  counter read request.
- idx  input  3  counter select: 0..3 = VC0..VC3, 4 = total, 5..7 = reserved.
- cuenta  output  ANCHO_CONTADOR  counter read value.
- valid_cuenta  output  1  cuenta valid strobe.

Behaviour:
- Reset (synchronous, high at a posedge) clears:
  - pop_out=0, push_out=0, data_out=0, cuenta=0, valid_cuenta=0.
  - rr pointer=0 (VC0 highest priority).
  - all counters=0.
  - in-flight pipeline flags.
- An in-flight word at reset is dropped; it is not pushed and not counted.
- FSM states:
  - RESET: entered while reset=1. Goes to ACTIVE on the first cycle with reset=0.
  - ACTIVE: arbitration enabled. Goes to PAUSE when almost_full_in=1.
  - PAUSE: pop_out forced to 0. Goes back to ACTIVE when almost_full_in=0.
  - Transitions are registered; the pause therefore takes effect one cycle after almost_full_in rises.
- Arbitration, ACTIVE only:
  - pop_out is combinational from state, empty_in and the rr pointer.
  - Grant goes to the first non-empty VC starting at the rr pointer, wrapping 3->0.
  - At most one pop bit per cycle. No grant if all empty_in=1.
  - On a grant to VCk, the pointer becomes (k+1) mod 4 at the next edge. No grant leaves the pointer unchanged.
- Pipeline (pop in cycle N):
  - Edge ending N: grant index and a valid flag are registered.
  - Cycle N+1: the FIFO presents the word on data_inK.
  - Edge ending N+1: data_out <= data_inK, push_out <= 1.
  - Pop-to-push latency is 2 cycles. Sustained throughput is 1 word/cycle.
  - push_out=0 in any cycle with no word in flight. data_out holds its last value.
- Back-pressure:
  - Up to 3 words can still be pushed after almost_full_in rises: 1 pause-registration cycle plus 2 in flight.
  - The downstream almost-full threshold (umbral_H) must leave at least 3 free entries.
  - Words in flight are always completed, never dropped, in PAUSE.
- Counters:
  - The counter of the pushed word's VC and the total counter increment at the edge where push_out is registered high.
  - Wrap modulo 2^ANCHO_CONTADOR; no saturation.
- Counter read:
  - req=1 at an edge gives cuenta <= counter[idx] and valid_cuenta <= 1 the next cycle.
  - idx 5..7 returns 0, still with valid_cuenta=1.
  - req=0 gives valid_cuenta=0; cuenta holds its value.
  - Read and increment of the same counter in one cycle returns the pre-increment value.
  - Holding req=1 with a changing idx gives one read per cycle.
- empty_in is trusted: a pop is never issued to an empty FIFO. Underflow is not checked here.

Decomposition:
- Shared PCIE package holds:
  - TAMANO_DATOS and ANCHO_CONTADOR defaults.
  - Number of VCs (4).
  - FSM state encodings RESET/ACTIVE/PAUSE.
  - idx codes (IDX_TOTAL=4).
- One natural sub-module: contadores_salida. It holds the five counters, the increment logic, and the req/idx read port.
- Arbiter, FSM and data pipeline stay in arbitro_rr_salida.

Test Plan:
- Reset mid-traffic:
  - Stimulus: stream active, reset=1 for 1 cycle.
  - Required: next cycle pop_out=0, push_out=0, data_out=0, all counters read 0. The in-flight word does not appear. First grant after reset goes to VC0.
- Round-robin fairness:
  - Stimulus: all 4 FIFOs non-empty, almost_full_in=0.
  - Required: pop_out sequence 0001,0010,0100,1000,0001. push_out follows 2 cycles later with data_in0..3 words in the same order (e.g. 12'h4A4, 12'h415, 12'h4A5, 12'hC8D).
- Skip empty:
  - Stimulus: empty_in=4'b0101, pointer at 0.
  - Required: grants alternate VC1, VC3. No pop to VC0 or VC2.
- Back-pressure:
  - Stimulus: almost_full_in=1 during a continuous stream.
  - Required: pop_out=0 from the next cycle; exactly the words already popped (at most 2 after the pause edge) are pushed; resume one cycle after almost_full_in=0, continuing from the saved pointer.
- Counter read:
  - Stimulus: after 3 words from VC2 and 2 from VC0, pulse req with idx=2, then 0, 4, 6.
  - Required: cuenta 3, 2, 5, 0 on consecutive cycles, with valid_cuenta=1 each.
- Wrap:
  - Stimulus: 33 words from VC1.
  - Required: idx=1 reads 1 and idx=4 reads 1 (modulo 32).

Source files
------------

// File: rtl/arbitro_rr_salida_pkg.sv
// Shared definitions for the PCIE egress round-robin merger: widths, VC count,
// FSM encodings and counter-select codes.
package arbitro_rr_salida_pkg;

  localparam int TAMANO_DATOS_DEF   = 12;
  localparam int ANCHO_CONTADOR_DEF = 5;
  localparam int NUM_VC             = 4;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  localparam logic [2:0] IDX_TOTAL = 3'd4;

  function automatic logic [1:0] vc_siguiente(input logic [1:0] vc);
    return vc + 2'd1;
  endfunction

endpackage

// File: rtl/arbitro_rr_salida_contadores.sv
// Per-VC and total pushed-word counters with a registered req/idx read port.
module contadores_salida
  import arbitro_rr_salida_pkg::*;
#(
  parameter int ANCHO_CONTADOR = ANCHO_CONTADOR_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc_i,
  input  logic [1:0]                inc_vc_i,
  input  logic                      req_i,
  input  logic [2:0]                idx_i,
  output logic [ANCHO_CONTADOR-1:0] cuenta_o,
  output logic                      valid_cuenta_o
);

  // Entries 0..3 are VC0..VC3, entry NUM_VC is the total.
  logic [ANCHO_CONTADOR-1:0] cnt_q [NUM_VC+1];
  logic [ANCHO_CONTADOR-1:0] sel;
  logic [ANCHO_CONTADOR-1:0] cuenta_q;
  logic                      valid_q;

  always_comb begin
    sel = '0;
    if (idx_i <= IDX_TOTAL) sel = cnt_q[idx_i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NUM_VC; i++) cnt_q[i] <= '0;
      cuenta_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      // The read samples the pre-increment value; wrap is natural overflow.
      if (inc_i) begin
        cnt_q[{1'b0, inc_vc_i}] <= cnt_q[{1'b0, inc_vc_i}] + ANCHO_CONTADOR'(1);
        cnt_q[NUM_VC]           <= cnt_q[NUM_VC] + ANCHO_CONTADOR'(1);
      end
      valid_q <= req_i;
      if (req_i) cuenta_q <= sel;
    end
  end

  assign cuenta_o       = cuenta_q;
  assign valid_cuenta_o = valid_q;

endmodule

// File: rtl/arbitro_rr_salida.sv
// Egress round-robin merger: drains four VC FIFOs into one stream with a
// two-cycle pop-to-push pipeline, honouring downstream almost-full.
module arbitro_rr_salida
  import arbitro_rr_salida_pkg::*;
#(
  parameter int TAMANO_DATOS   = TAMANO_DATOS_DEF,
  parameter int ANCHO_CONTADOR = ANCHO_CONTADOR_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                empty_in,
  input  logic [TAMANO_DATOS-1:0]   data_in0,
  input  logic [TAMANO_DATOS-1:0]   data_in1,
  input  logic [TAMANO_DATOS-1:0]   data_in2,
  input  logic [TAMANO_DATOS-1:0]   data_in3,
  input  logic                      almost_full_in,
  output logic [3:0]                pop_out,
  output logic [TAMANO_DATOS-1:0]   data_out,
  output logic                      push_out,
  input  logic                      req,
  input  logic [2:0]                idx,
  output logic [ANCHO_CONTADOR-1:0] cuenta,
  output logic                      valid_cuenta
);

  logic [1:0]              state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    grant;
  logic [1:0]              grant_vc;
  logic [1:0]              cand;
  logic                    vld_p0;
  logic [1:0]              vc_p0;
  logic                    vld_p1;
  logic [TAMANO_DATOS-1:0] data_p1;
  logic [TAMANO_DATOS-1:0] data_sel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_ACTIVE;
      ST_ACTIVE: if (almost_full_in) state_d = ST_PAUSE;
      ST_PAUSE:  if (!almost_full_in) state_d = ST_ACTIVE;
      default:   state_d = ST_RESET;
    endcase
  end

  // First non-empty VC at or after the pointer, wrapping 3->0.
  always_comb begin
    grant    = 1'b0;
    grant_vc = ptr_q;
    cand     = ptr_q;
    for (int i = 0; i < NUM_VC; i++) begin
      cand = ptr_q + 2'(i);
      if (!grant && !empty_in[cand] && (state_q == ST_ACTIVE)) begin
        grant    = 1'b1;
        grant_vc = cand;
      end
    end
  end

  assign pop_out = grant ? 4'(4'b0001 << grant_vc) : 4'b0000;
  assign ptr_d   = grant ? vc_siguiente(grant_vc) : ptr_q;

  always_comb begin
    case (vc_p0)
      2'd0:    data_sel = data_in0;
      2'd1:    data_sel = data_in1;
      2'd2:    data_sel = data_in2;
      default: data_sel = data_in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      ptr_q   <= 2'd0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // p0: grant registered while the FIFO fetches the word
      vld_p0  <= grant;
      // p1: FIFO word captured and pushed downstream
      vld_p1  <= vld_p0;
      if (vld_p0) data_p1 <= data_sel;
    end
  end

  always_ff @(posedge clk) begin
    vc_p0 <= grant_vc;
  end

  assign push_out = vld_p1;
  assign data_out = data_p1;

  contadores_salida #(
    .ANCHO_CONTADOR(ANCHO_CONTADOR)
  ) u_contadores (
    .clk            (clk),
    .reset          (reset),
    .inc_i          (vld_p0),
    .inc_vc_i       (vc_p0),
    .req_i          (req),
    .idx_i          (idx),
    .cuenta_o       (cuenta),
    .valid_cuenta_o (valid_cuenta)
  );

endmodule

// File: tb/tb_arbitro_rr_salida.sv
// Bench for arbitro_rr_salida: queue-based FIFO models, a behavioural
// reference checked every cycle, and literal expectations for key scenarios.
module tb_arbitro_rr_salida;

  localparam int TD = 12;
  localparam int AC = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    empty_in;
  logic [TD-1:0] din [4];
  logic          almost_full_in;
  logic [3:0]    pop_out;
  logic [TD-1:0] data_out;
  logic          push_out;
  logic          req;
  logic [2:0]    idx;
  logic [AC-1:0] cuenta;
  logic          valid_cuenta;

  always #5 clk = ~clk;

  arbitro_rr_salida dut (
    .clk            (clk),
    .reset          (reset),
    .empty_in       (empty_in),
    .data_in0       (din[0]),
    .data_in1       (din[1]),
    .data_in2       (din[2]),
    .data_in3       (din[3]),
    .almost_full_in (almost_full_in),
    .pop_out        (pop_out),
    .data_out       (data_out),
    .push_out       (push_out),
    .req            (req),
    .idx            (idx),
    .cuenta         (cuenta),
    .valid_cuenta   (valid_cuenta)
  );

  typedef logic [TD-1:0] wq_t [$];
  wq_t fifo_q [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus
  bit       s_reset = 1'b1;
  bit       s_af    = 1'b0;
  bit       s_req   = 1'b0;
  bit [2:0] s_idx   = 3'd0;

  // behavioural reference
  bit            primed   = 1'b0;
  bit            m_arb_on = 1'b0;
  bit            m_rs     = 1'b1;
  int            m_ptr    = 0;
  bit            m_p1_v   = 1'b0;
  int            m_p1_vc  = 0;
  logic [TD-1:0] m_p1_d   = '0;
  bit            m_push   = 1'b0;
  logic [TD-1:0] m_data   = '0;
  int            m_cnt [5];
  int            m_cuenta = 0;
  bit            m_vld_c  = 1'b0;
  logic [3:0]    pend_pop = 4'b0000;

  logic [3:0]    log_pop    [8192];
  logic          log_push   [8192];
  logic [TD-1:0] log_data   [8192];
  logic [AC-1:0] log_cuenta [8192];
  logic          log_vc     [8192];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic run_cycle();
    int g;
    logic [3:0] exp_pop;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (pend_pop[k] === 1'b1 && fifo_q[k].size() > 0) din[k] = fifo_q[k].pop_front();
    for (int k = 0; k < 4; k++) empty_in[k] = (fifo_q[k].size() == 0);
    reset          = s_reset;
    almost_full_in = s_af;
    req            = s_req;
    idx            = s_idx;
    #1;
    g = -1;
    if (m_arb_on)
      for (int i = 0; i < 4; i++)
        if (g < 0 && fifo_q[(m_ptr + i) % 4].size() > 0) g = (m_ptr + i) % 4;
    exp_pop = (g >= 0) ? 4'(1 << g) : 4'b0000;
    if (primed) begin
      check("pop_out", pop_out, exp_pop);
      check("push_out", push_out, m_push);
      check("data_out", data_out, m_data);
      check("valid_cuenta", valid_cuenta, m_vld_c);
      check("cuenta", cuenta, m_cuenta);
    end
    log_pop[cyc]    = pop_out;
    log_push[cyc]   = push_out;
    log_data[cyc]   = data_out;
    log_cuenta[cyc] = cuenta;
    log_vc[cyc]     = valid_cuenta;
    pend_pop        = pop_out;
    // advance the reference across the coming edge
    if (s_reset) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_ptr = 0; m_p1_v = 0; m_push = 0; m_data = '0;
      m_cuenta = 0; m_vld_c = 0; m_rs = 1; m_arb_on = 0;
      primed = 1'b1;
    end else begin
      if (s_req) begin
        m_vld_c  = 1'b1;
        m_cuenta = (s_idx < 4) ? m_cnt[s_idx] : ((s_idx == 4) ? m_cnt[4] : 0);
      end else begin
        m_vld_c = 1'b0;
      end
      m_push = m_p1_v;
      if (m_p1_v) begin
        m_data = m_p1_d;
        m_cnt[m_p1_vc] = (m_cnt[m_p1_vc] + 1) % 32;
        m_cnt[4]       = (m_cnt[4] + 1) % 32;
      end
      m_p1_v = (g >= 0);
      if (g >= 0) begin
        m_p1_vc = g;
        m_p1_d  = fifo_q[g][0];
        m_ptr   = (g + 1) % 4;
      end
      m_arb_on = m_rs || !s_af;
      m_rs     = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    s_reset = 1'b1;
    repeat (n) run_cycle();
    s_reset = 1'b0;
  endtask

  task automatic fill_all(input int n);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < n; j++) fifo_q[k].push_back(TD'($urandom_range(0, 4095)));
  endtask

  initial begin
    int c0, p, r, x, s;
    for (int k = 0; k < 4; k++) din[k] = '0;
    reset = 1'b1; empty_in = 4'hF; almost_full_in = 1'b0; req = 1'b0; idx = 3'd0;

    // round-robin with all four FIFOs non-empty
    do_reset(3);
    fifo_q[0].push_back(12'h4A4); fifo_q[0].push_back(12'h111);
    fifo_q[1].push_back(12'h415);
    fifo_q[2].push_back(12'h4A5);
    fifo_q[3].push_back(12'hC8D);
    c0 = cyc;
    repeat (10) run_cycle();
    check("rr_first_pop", log_pop[c0], 4'b0000);
    check("rr_pop0", log_pop[c0+1], 4'b0001);
    check("rr_pop1", log_pop[c0+2], 4'b0010);
    check("rr_pop2", log_pop[c0+3], 4'b0100);
    check("rr_pop3", log_pop[c0+4], 4'b1000);
    check("rr_pop4", log_pop[c0+5], 4'b0001);
    check("rr_push_lat", log_push[c0+2], 1'b0);
    check("rr_data0", log_data[c0+3], 12'h4A4);
    check("rr_data1", log_data[c0+4], 12'h415);
    check("rr_data2", log_data[c0+5], 12'h4A5);
    check("rr_data3", log_data[c0+6], 12'hC8D);
    check("rr_data4", log_data[c0+7], 12'h111);

    // skip empty FIFOs
    do_reset(2);
    for (int j = 0; j < 3; j++) begin
      fifo_q[1].push_back(TD'(12'h100 + j));
      fifo_q[3].push_back(TD'(12'h300 + j));
    end
    c0 = cyc;
    repeat (10) run_cycle();
    check("skip_pop0", log_pop[c0+1], 4'b0010);
    check("skip_pop1", log_pop[c0+2], 4'b1000);
    check("skip_pop2", log_pop[c0+3], 4'b0010);
    check("skip_pop3", log_pop[c0+4], 4'b1000);

    // counter read after 3 words of VC2 and 2 of VC0
    do_reset(2);
    for (int j = 0; j < 3; j++) fifo_q[2].push_back(TD'(12'h200 + j));
    for (int j = 0; j < 2; j++) fifo_q[0].push_back(TD'(12'h000 + j));
    repeat (12) run_cycle();
    r = cyc;
    s_req = 1'b1;
    s_idx = 3'd2; run_cycle();
    s_idx = 3'd0; run_cycle();
    s_idx = 3'd4; run_cycle();
    s_idx = 3'd6; run_cycle();
    s_req = 1'b0; run_cycle();
    check("rd_vc2", log_cuenta[r+1], 5'd3);
    check("rd_vc0", log_cuenta[r+2], 5'd2);
    check("rd_total", log_cuenta[r+3], 5'd5);
    check("rd_rsvd", log_cuenta[r+4], 5'd0);
    check("rd_rsvd_vld", log_vc[r+4], 1'b1);
    check("rd_idle_vld", log_vc[r+5], 1'b0);

    // counter wrap: 33 words from VC1
    do_reset(2);
    for (int j = 0; j < 33; j++) fifo_q[1].push_back(TD'(j));
    repeat (40) run_cycle();
    r = cyc;
    s_req = 1'b1;
    s_idx = 3'd1; run_cycle();
    s_idx = 3'd4; run_cycle();
    s_req = 1'b0; run_cycle();
    check("wrap_vc1", log_cuenta[r+1], 5'd1);
    check("wrap_total", log_cuenta[r+2], 5'd1);

    // back-pressure in the middle of a continuous stream
    do_reset(2);
    fill_all(8);
    repeat (6) run_cycle();
    p = cyc;
    s_af = 1'b1;
    repeat (6) run_cycle();
    r = cyc;
    s_af = 1'b0;
    repeat (10) run_cycle();
    check("bp_last_pop", log_pop[p], 4'b0010);
    s = 0;
    for (int i = p + 1; i < p + 6; i++) s += (log_pop[i] != 4'b0000) ? 1 : 0;
    check("bp_paused_pops", s, 0);
    s = 0;
    for (int i = p; i < p + 6; i++) s += (log_push[i] === 1'b1) ? 1 : 0;
    check("bp_drained", s, 3);
    check("bp_resume_wait", log_pop[r], 4'b0000);
    check("bp_resume_ptr", log_pop[r+1], 4'b0100);

    // reset in the middle of traffic
    fill_all(4);
    repeat (2) run_cycle();
    x = cyc;
    s_reset = 1'b1; run_cycle();
    s_reset = 1'b0;
    s_req = 1'b1;
    s_idx = 3'd4; run_cycle();
    s_idx = 3'd0; run_cycle();
    s_idx = 3'd3; run_cycle();
    s_req = 1'b0;
    repeat (4) run_cycle();
    check("rst_pop", log_pop[x+1], 4'b0000);
    check("rst_push", log_push[x+1], 1'b0);
    check("rst_data", log_data[x+1], 12'h000);
    check("rst_inflight", log_push[x+2], 1'b0);
    check("rst_first_grant", log_pop[x+2], 4'b0001);
    check("rst_cnt_total", log_cuenta[x+2], 5'd0);
    check("rst_cnt_vc0", log_cuenta[x+3], 5'd0);
    check("rst_cnt_vc3", log_cuenta[x+4], 5'd0);

    // randomized traffic, back-pressure, reads and occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 99) < 22 && fifo_q[k].size() < 12)
          fifo_q[k].push_back(TD'($urandom_range(0, 4095)));
      if ($urandom_range(0, 99) < 10) s_af = ~s_af;
      s_req   = ($urandom_range(0, 99) < 40);
      s_idx   = 3'($urandom_range(0, 7));
      s_reset = ($urandom_range(0, 299) == 0);
      run_cycle();
    end
    s_reset = 1'b0; s_req = 1'b0; s_af = 1'b0;
    repeat (4) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
